// File: rtl/fp_mul_issuer_if.sv
// Operand/result streams plus the start/busy/done multiplier handshake.
// The issuer uses the master modport; the environment (upstream, downstream, multiplier) uses slave.
interface fp_mul_issuer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_z;

    modport master (
        input  in_valid, in_a, in_b, out_ready, mul_busy, mul_done, mul_z,
        output in_ready, out_valid, out_z, mul_start, mul_a, mul_b
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, mul_busy, mul_done, mul_z,
        input  in_ready, out_valid, out_z, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/fp_mul_issuer.sv
// Issues upstream operand pairs to a start/busy/done FP32 multiplier and
// returns each product on a one-entry downstream slot, with protocol timeouts.
module fp_mul_issuer #(
    parameter int CLR_TIMEOUT  = 2000,
    parameter int DONE_TIMEOUT = 200000,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_mul_issuer_if.master   bus,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  op_count
);
    localparam int MAX_T = (CLR_TIMEOUT > DONE_TIMEOUT) ? CLR_TIMEOUT : DONE_TIMEOUT;
    localparam int TMO_W = $clog2(MAX_T + 1);
    localparam logic [TMO_W-1:0] CLR_LIM  = TMO_W'(CLR_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] DONE_LIM = TMO_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [TMO_W-1:0]   tmo;
    logic [31:0]        hold;
    logic               slot_free;
    logic               take_in, fire, to_out, to_hold, from_hold, abort;

    assign bus.in_ready = (state == IDLE) && rst_n;
    assign slot_free    = !bus.out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_in   = 1'b0;
        fire      = 1'b0;
        to_out    = 1'b0;
        to_hold   = 1'b0;
        from_hold = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    take_in   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.mul_busy) begin
                    fire      = 1'b1;
                    state_nxt = WAIT_CLR;
                end else if (tmo >= DONE_LIM) begin
                    abort = 1'b1;
                end
            end
            WAIT_CLR: begin
                // done seen during the start cycle may be stale from the previous op
                if (!bus.mul_start && !bus.mul_done) state_nxt = WAIT_DONE;
                else if (tmo >= CLR_LIM)             abort     = 1'b1;
            end
            WAIT_DONE: begin
                if (bus.mul_done) begin
                    if (slot_free) begin
                        to_out    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        to_hold   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (tmo >= DONE_LIM) begin
                    abort = 1'b1;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    from_hold = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo           <= '0;
            hold          <= '0;
            bus.mul_start <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_z     <= '0;
            timeout_err   <= 1'b0;
            op_count      <= '0;
        end else begin
            tmo           <= (state_nxt != state || state == IDLE) ? '0 : tmo + 1'b1;
            bus.mul_start <= fire;
            if (take_in) begin
                bus.mul_a <= bus.in_a;
                bus.mul_b <= bus.in_b;
            end
            if (to_hold) hold <= bus.mul_z;
            // a load replaces a draining result in the same edge
            if (to_out) begin
                bus.out_z     <= bus.mul_z;
                bus.out_valid <= 1'b1;
            end else if (from_hold) begin
                bus.out_z     <= hold;
                bus.out_valid <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (to_out || from_hold) op_count <= op_count + 1'b1;
            if (abort) timeout_err <= 1'b1;
        end
    end
endmodule
